// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - shared types and constants for the debug UART command sequencer
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_EXEC,
    S_RD_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] OPC_WR   = 8'h01;
  localparam logic [7:0] OPC_RD   = 8'h02;
  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam logic [7:0] ACK_DEF  = 8'h5A;
  localparam logic [7:0] NAK_DEF  = 8'hEE;

endpackage

// File: rtl/uart_dbg_timeout.sv
// rtl/uart_dbg_timeout.sv - restartable cycle timer with a terminal-count pulse
module uart_dbg_timeout #(
  parameter int TO = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TO + 1);

  logic [W-1:0] cnt;

  // tc fires on the TO-th enabled cycle after the last restart; a restart in that cycle wins
  assign tc = en && !restart && (cnt == W'(TO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || !en || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_dbg_cmd.sv
// rtl/uart_dbg_cmd.sv - frames UART bytes into debug packets and runs one bus access per packet
module uart_dbg_cmd
  import uart_dbg_pkg::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] SYNC       = SYNC_DEF,
  parameter logic [7:0] ACK        = ACK_DEF,
  parameter logic [7:0] NAK        = NAK_DEF,
  parameter int         BYTE_TO    = 100000,
  parameter int         RD_TO      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rxd,
  input  logic                    rxv,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [7:0]              addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    rd_ack,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              err_cnt,
  output logic                    busy
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);

  state_t        state;
  logic [7:0]    opc;
  logic [7:0]    csum_acc;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] resp_cnt;
  logic [DW-1:0] resp_sh;
  logic [DW-1:0] resp_next;
  logic          byte_en;
  logic          byte_tc;
  logic          rd_tmr_en;
  logic          rd_tc;
  logic          bad_opc;
  logic          csum_bad;
  logic          err_evt;

  assign busy      = (state != S_IDLE);
  assign byte_en   = state inside {S_OPC, S_ADDR, S_DATA, S_CSUM};
  // the rd_en cycle itself neither accepts rd_ack nor counts toward the read timeout
  assign rd_tmr_en = (state == S_RD_WAIT) && !rd_en;
  assign bad_opc   = (opc != OPC_WR) && (opc != OPC_RD);
  assign csum_bad  = (rxd != csum_acc) || bad_opc;
  assign resp_next = resp_sh << 8;

  // every error source in a cycle collapses into a single increment
  assign err_evt = (rxv && (state inside {S_EXEC, S_RD_WAIT, S_RESP}))
                || byte_tc
                || (rd_tc && !rd_ack)
                || ((state == S_CSUM) && rxv && csum_bad);

  uart_dbg_timeout #(.TO(BYTE_TO)) u_byte_to (
    .clk     (clk),
    .rst     (rst),
    .restart (rxv),
    .en      (byte_en),
    .tc      (byte_tc)
  );

  uart_dbg_timeout #(.TO(RD_TO)) u_rd_to (
    .clk     (clk),
    .rst     (rst),
    .restart (1'b0),
    .en      (rd_tmr_en),
    .tc      (rd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      opc      <= '0;
      addr     <= '0;
      csum_acc <= '0;
      dcnt     <= '0;
      wr_data  <= '0;
      resp_sh  <= '0;
      resp_cnt <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      err_cnt  <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (rxv && (rxd == SYNC)) state <= S_OPC;
        end
        S_OPC: begin
          if (rxv) begin
            opc      <= rxd;
            csum_acc <= rxd;
            state    <= S_ADDR;
          end else if (byte_tc) begin
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (rxv) begin
            addr     <= rxd;
            csum_acc <= csum_acc ^ rxd;
            dcnt     <= '0;
            state    <= (opc == OPC_WR) ? S_DATA : S_CSUM;
          end else if (byte_tc) begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rxv) begin
            wr_data  <= (wr_data << 8) | DW'(rxd);
            csum_acc <= csum_acc ^ rxd;
            dcnt     <= dcnt + CW'(1);
            if (dcnt == CW'(DATA_BYTES - 1)) state <= S_CSUM;
          end else if (byte_tc) begin
            state <= S_IDLE;
          end
        end
        S_CSUM: begin
          if (rxv) begin
            if (csum_bad) begin
              resp_sh  <= DW'(NAK) << (DW - 8);
              resp_cnt <= CW'(1);
              state    <= S_RESP;
            end else begin
              state <= S_EXEC;
            end
          end else if (byte_tc) begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (opc == OPC_WR) begin
            wr_en    <= 1'b1;
            resp_sh  <= DW'(ACK) << (DW - 8);
            resp_cnt <= CW'(1);
            state    <= S_RESP;
          end else begin
            rd_en <= 1'b1;
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_ack && !rd_en) begin
            resp_sh  <= rd_data;
            resp_cnt <= CW'(DATA_BYTES);
            state    <= S_RESP;
          end else if (rd_tc) begin
            resp_sh  <= DW'(NAK) << (DW - 8);
            resp_cnt <= CW'(1);
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_sh[DW-1 -: 8];
          end else if (tx_ready) begin
            if (resp_cnt == CW'(1)) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              resp_sh  <= resp_next;
              resp_cnt <= resp_cnt - CW'(1);
              tx_data  <= resp_next[DW-1 -: 8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_cmd.sv
// tb/tb_uart_dbg_cmd.sv - self-checking bench for uart_dbg_cmd
module tb_uart_dbg_cmd;

  localparam int DB  = 4;
  localparam int BTO = 60;
  localparam int RTO = 30;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h5A;
  localparam logic [7:0] NAK  = 8'hEE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = '0;
  logic        rxv = 1'b0;
  logic        wr_en, rd_en, tx_valid, busy;
  logic [7:0]  addr, tx_data, err_cnt;
  logic [31:0] wr_data;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        tx_ready;

  always #5 clk = ~clk;

  uart_dbg_cmd #(
    .DATA_BYTES (DB),
    .BYTE_TO    (BTO),
    .RD_TO      (RTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxv      (rxv),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] tx_word = '0;
  int          tx_n = 0;
  int          wr_n = 0;
  logic [39:0] wr_last = '0;
  int          rd_n = 0;

  bit          rdy_rand = 1'b0;
  bit          rdy_hold = 1'b1;
  bit          ack_on = 1'b1;
  int          ack_dly = 5;
  logic [31:0] ack_val = '0;

  logic [63:0] exp_word, obs_word;
  int          exp_n, obs_n, exp_wr, obs_wr, exp_rd, obs_rd;
  logic [39:0] exp_wrv;
  int          exp_err = 0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_word <= {tx_word[55:0], tx_data};
      tx_n    <= tx_n + 1;
    end
    if (wr_en) begin
      wr_n    <= wr_n + 1;
      wr_last <= {addr, wr_data};
    end
    if (rd_en) rd_n <= rd_n + 1;
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
    end
  end

  // read responder: ack_dly==0 raises rd_ack inside the rd_en cycle itself
  initial begin
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_en && ack_on) begin
        if (ack_dly != 0) begin
          repeat (ack_dly) @(posedge clk);
          #1;
        end
        rd_ack  = 1'b1;
        rd_data = ack_val;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
      end
    end
  end

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = b;
    rxv = 1'b1;
    tick(1);
    rxv = 1'b0;
    rxd = '0;
  endtask

  // reference: response bytes, bus activity and error count derived from packet rules
  task automatic model(input logic [7:0] opc, input logic [7:0] a, input logic [31:0] d, input bit bad);
    exp_wr  = 0;
    exp_rd  = (!bad && opc == 8'h02) ? 1 : 0;
    exp_wrv = {a, d};
    if (bad || !(opc == 8'h01 || opc == 8'h02)) begin
      exp_n = 1; exp_word = 64'(NAK); exp_err = sat(exp_err + 1);
    end else if (opc == 8'h01) begin
      exp_n = 1; exp_word = 64'(ACK); exp_wr = 1;
    end else if (ack_on && ack_dly >= 1 && ack_dly <= RTO) begin
      exp_n = DB; exp_word = 64'(ack_val);
    end else begin
      exp_n = 1; exp_word = 64'(NAK); exp_err = sat(exp_err + 1);
    end
  endtask

  task automatic send_pkt(input logic [7:0] opc, input logic [7:0] a, input logic [31:0] d, input bit bad);
    logic [7:0] cs;
    cs = opc ^ a;
    send_byte(SYNC);
    send_byte(opc);
    send_byte(a);
    if (opc == 8'h01) begin
      for (int i = DB - 1; i >= 0; i--) begin
        send_byte(d[8*i +: 8]);
        cs = cs ^ d[8*i +: 8];
      end
    end
    if (bad) cs = cs ^ 8'h5C;
    send_byte(cs);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait busy=%0b want 0 after %0d cycles", busy, budget);
    end
  endtask

  task automatic observe(input int tb, input int wb, input int rb);
    obs_n    = tx_n - tb;
    obs_word = (obs_n >= 8) ? tx_word : tx_word & ((64'd1 << (8 * obs_n)) - 64'd1);
    obs_wr   = wr_n - wb;
    obs_rd   = rd_n - rb;
  endtask

  task automatic xact(input logic [7:0] opc, input logic [7:0] a, input logic [31:0] d, input bit bad);
    int tb, wb, rb;
    tb = tx_n; wb = wr_n; rb = rd_n;
    model(opc, a, d, bad);
    send_pkt(opc, a, d, bad);
    wait_idle(RTO + 200);
    observe(tb, wb, rb);
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({wr_en, rd_en, addr, wr_data, tx_data, tx_valid, err_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%0b rd=%0b addr=%h wd=%h tx=%h tv=%0b err=%0d busy=%0b want all 0",
               wr_en, rd_en, addr, wr_data, tx_data, tx_valid, err_cnt, busy);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    xact(8'h01, 8'h10, 32'hDEADBEEF, 1'b0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'h5A) begin
      errors++; $display("FAIL write_tx got n=%0d %h want n=1 5a", obs_n, obs_word);
    end
    checks++;
    if (obs_wr != 1 || wr_last !== {8'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL write_bus got n=%0d %h want n=1 10deadbeef", obs_wr, wr_last);
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL write_err got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_read();
    ack_on = 1'b1; ack_dly = 5; ack_val = 32'h12345678;
    xact(8'h02, 8'h20, 32'h0, 1'b0);
    checks++;
    if (obs_n != 4 || obs_word !== 64'h12345678) begin
      errors++; $display("FAIL read_tx got n=%0d %h want n=4 12345678", obs_n, obs_word);
    end
    checks++;
    if (obs_rd != 1 || obs_wr != 0 || addr !== 8'h20) begin
      errors++; $display("FAIL read_bus got rd=%0d wr=%0d addr=%h want rd=1 wr=0 addr=20", obs_rd, obs_wr, addr);
    end
  endtask

  task automatic test_bad_csum();
    int tb, wb;
    tb = tx_n; wb = wr_n;
    model(8'h01, 8'h10, 32'h0, 1'b1);
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h10);
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    wait_idle(100);
    observe(tb, wb, 0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'hEE || obs_wr != 0) begin
      errors++; $display("FAIL bad_csum got n=%0d %h wr=%0d want n=1 ee wr=0", obs_n, obs_word, obs_wr);
    end
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++; $display("FAIL bad_csum_err got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_timeout();
    int tb, wb;
    tb = tx_n; wb = wr_n;
    send_byte(SYNC); send_byte(8'h01);
    tick(BTO - 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early busy=%0b want 1", busy);
    end
    tick(10);
    exp_err = sat(exp_err + 1);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 8'(exp_err) || tx_n != tb || wr_n != wb) begin
      errors++; $display("FAIL timeout got busy=%0b err=%0d tx=%0d wr=%0d want 0 %0d 0 0",
                         busy, err_cnt, tx_n - tb, wr_n - wb, exp_err);
    end
    xact(8'h01, 8'h33, 32'hA1B2C3D4, 1'b0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'h5A || obs_wr != 1 || wr_last !== {8'h33, 32'hA1B2C3D4}) begin
      errors++; $display("FAIL timeout_after got n=%0d %h wr=%0d %h", obs_n, obs_word, obs_wr, wr_last);
    end
  endtask

  task automatic test_read_noack();
    int tb, c;
    ack_on = 1'b0; rdy_hold = 1'b0;
    tb = tx_n;
    model(8'h02, 8'h20, 32'h0, 1'b0);
    send_pkt(8'h02, 8'h20, 32'h0, 1'b0);
    c = 0;
    while (!tx_valid && c < RTO + 20) begin
      tick(1);
      c++;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== NAK) begin
      errors++; $display("FAIL noack_nak got tv=%0b %h want 1 ee", tx_valid, tx_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== NAK) begin
        errors++; $display("FAIL noack_hold cyc %0d got tv=%0b %h want 1 ee", i, tx_valid, tx_data);
      end
    end
    rdy_hold = 1'b1;
    wait_idle(50);
    observe(tb, 0, 0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'hEE || err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL noack_tx got n=%0d %h err=%0d want n=1 ee err=%0d", obs_n, obs_word, err_cnt, exp_err);
    end
    ack_on = 1'b1; ack_dly = 0; ack_val = 32'hCAFE0001;
    xact(8'h02, 8'h44, 32'h0, 1'b0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'hEE || err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL early_ack got n=%0d %h err=%0d want n=1 ee err=%0d", obs_n, obs_word, err_cnt, exp_err);
    end
  endtask

  task automatic test_garbage();
    send_byte(8'h00);
    send_byte(8'hFF);
    tick(2);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL garbage got busy=%0b err=%0d want 0 %0d", busy, err_cnt, exp_err);
    end
    xact(8'h01, 8'h5E, 32'h00C0FFEE, 1'b0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'h5A || wr_last !== {8'h5E, 32'h00C0FFEE}) begin
      errors++; $display("FAIL garbage_pkt got n=%0d %h %h", obs_n, obs_word, wr_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  opc, a;
    logic [31:0] d;
    bit          bad;
    int          r;
    rdy_rand = 1'b1;
    ack_on = 1'b1;
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      a = 8'($urandom); d = $urandom; bad = 1'b0;
      ack_dly = $urandom_range(1, 10); ack_val = $urandom;
      if (r < 4) opc = 8'h01;
      else if (r < 8) opc = 8'h02;
      else if (r == 8) opc = 8'($urandom_range(3, 255));
      else begin opc = 8'($urandom_range(1, 2)); bad = 1'b1; end
      xact(opc, a, d, bad);
      checks++;
      if (obs_n != exp_n || obs_word !== exp_word) begin
        errors++; $display("FAIL rand_tx pkt %0d opc %h got n=%0d %h want n=%0d %h", k, opc, obs_n, obs_word, exp_n, exp_word);
      end
      checks++;
      if (obs_wr != exp_wr || obs_rd != exp_rd || (exp_wr == 1 && wr_last !== exp_wrv)) begin
        errors++; $display("FAIL rand_bus pkt %0d got wr=%0d rd=%0d %h want wr=%0d rd=%0d %h",
                           k, obs_wr, obs_rd, wr_last, exp_wr, exp_rd, exp_wrv);
      end
      checks++;
      if (err_cnt !== 8'(exp_err)) begin
        errors++; $display("FAIL rand_err pkt %0d got %0d want %0d", k, err_cnt, exp_err);
      end
    end
    rdy_rand = 1'b0;
  endtask

  task automatic test_overrun();
    int tb, wb;
    rdy_hold = 1'b0;
    tb = tx_n; wb = wr_n;
    model(8'h01, 8'h77, 32'h01020304, 1'b0);
    send_pkt(8'h01, 8'h77, 32'h01020304, 1'b0);
    tick(2);
    for (int i = 0; i < 300; i++) begin
      send_byte((i == 299) ? SYNC : 8'($urandom));
      exp_err = sat(exp_err + 1);
    end
    checks++;
    if (err_cnt !== 8'd255 || err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL overrun_sat got %0d want 255", err_cnt);
    end
    rdy_hold = 1'b1;
    wait_idle(20);
    observe(tb, wb, 0);
    tick(3);
    checks++;
    if (obs_n != 1 || obs_word !== 64'h5A || obs_wr != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_tx got n=%0d %h wr=%0d busy=%0b want n=1 5a wr=1 busy=0",
                         obs_n, obs_word, obs_wr, busy);
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    wb = wr_n;
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h10); send_byte(8'hDE); send_byte(8'hAD);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, rd_en, addr, wr_data, tx_data, tx_valid, err_cnt, busy} !== '0) begin
      errors++; $display("FAIL rst_mid got addr=%h wd=%h err=%0d busy=%0b want all 0", addr, wr_data, err_cnt, busy);
    end
    exp_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
    checks++;
    if (wr_n != wb || busy !== 1'b0) begin
      errors++; $display("FAIL rst_partial got wr=%0d busy=%0b want 0 0", wr_n - wb, busy);
    end
    xact(8'h01, 8'h10, 32'hDEADBEEF, 1'b0);
    checks++;
    if (obs_n != 1 || obs_word !== 64'h5A || obs_wr != 1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_after got n=%0d %h wr=%0d err=%0d", obs_n, obs_word, obs_wr, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_csum();
    test_timeout();
    test_read_noack();
    test_garbage();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
